// File: rtl/writeback_arbiter.sv
// writeback_arbiter: two-source (ALU/load) result FIFOs round-robin arbitrated onto the
// register file write port, with combinational pending-write hazard queries for decode.
module writeback_arbiter #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_addr,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_addr,
    input  logic [WIDTH-1:0] mem_data,
    output logic             we3,
    output logic [4:0]       wa3,
    output logic [WIDTH-1:0] wd3,
    input  logic [4:0]       q_addr1,
    input  logic [4:0]       q_addr2,
    output logic             q_pend1,
    output logic             q_pend2,
    output logic             idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    typedef enum logic {ALU, MEM} src_t;

    src_t             last_grant, next_grant;
    logic [4:0]       a_addr [DEPTH];
    logic [WIDTH-1:0] a_data [DEPTH];
    logic [4:0]       m_addr [DEPTH];
    logic [WIDTH-1:0] m_data [DEPTH];
    logic [PW-1:0]    a_rd, a_wr, m_rd, m_wr, a_off, m_off;
    logic [CW-1:0]    a_cnt, m_cnt;
    logic             a_push, m_push, a_pop, m_pop, hit1, hit2;
    logic [4:0]       head_addr;
    logic [WIDTH-1:0] head_data;

    assign alu_ready = !rst && a_cnt != FULL;
    assign mem_ready = !rst && m_cnt != FULL;
    assign a_push    = alu_valid && alu_ready;
    assign m_push    = mem_valid && mem_ready;
    assign idle      = a_cnt == '0 && m_cnt == '0 && !we3;

    always_comb begin
        a_pop      = a_cnt != '0 && (m_cnt == '0 || last_grant == MEM);
        m_pop      = m_cnt != '0 && !a_pop;
        next_grant = (a_cnt != '0 && m_cnt != '0) ? (a_pop ? ALU : MEM) : last_grant;
        head_addr  = a_pop ? a_addr[a_rd] : m_addr[m_rd];
        head_data  = a_pop ? a_data[a_rd] : m_data[m_rd];
    end

    // Payload storage needs no reset: occupancy is tracked by the counts alone.
    always_ff @(posedge clk) begin
        if (a_push) begin
            a_addr[a_wr] <= alu_addr;
            a_data[a_wr] <= alu_data;
        end
        if (m_push) begin
            m_addr[m_wr] <= mem_addr;
            m_data[m_wr] <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rd       <= '0;
            a_wr       <= '0;
            a_cnt      <= '0;
            m_rd       <= '0;
            m_wr       <= '0;
            m_cnt      <= '0;
            last_grant <= MEM;
            we3        <= 1'b0;
            wa3        <= '0;
            wd3        <= '0;
        end else begin
            a_rd       <= a_rd + PW'(a_pop);
            a_wr       <= a_wr + PW'(a_push);
            a_cnt      <= a_cnt + CW'(a_push) - CW'(a_pop);
            m_rd       <= m_rd + PW'(m_pop);
            m_wr       <= m_wr + PW'(m_push);
            m_cnt      <= m_cnt + CW'(m_push) - CW'(m_pop);
            last_grant <= next_grant;
            we3        <= (a_pop || m_pop) && head_addr != 5'd31;
            if (a_pop || m_pop) begin
                wa3 <= head_addr;
                wd3 <= head_data;
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        hit1  = we3 && wa3 == q_addr1;
        hit2  = we3 && wa3 == q_addr2;
        a_off = '0;
        m_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            a_off = PW'(i) - a_rd;
            m_off = PW'(i) - m_rd;
            if (CW'(a_off) < a_cnt) begin
                hit1 = hit1 || a_addr[i] == q_addr1;
                hit2 = hit2 || a_addr[i] == q_addr2;
            end
            if (CW'(m_off) < m_cnt) begin
                hit1 = hit1 || m_addr[i] == q_addr1;
                hit2 = hit2 || m_addr[i] == q_addr2;
            end
        end
        q_pend1 = q_addr1 != 5'd31 && hit1;
        q_pend2 = q_addr2 != 5'd31 && hit2;
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed scenarios plus randomized traffic checked against a
// queue-based model of the two result FIFOs and the round-robin write port.
module tb_writeback_arbiter;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alu_valid = 1'b0, mem_valid = 1'b0;
    logic             alu_ready, mem_ready;
    logic [4:0]       alu_addr = '0, mem_addr = '0, q_addr1 = '0, q_addr2 = '0;
    logic [WIDTH-1:0] alu_data = '0, mem_data = '0;
    logic             we3, q_pend1, q_pend2, idle;
    logic [4:0]       wa3;
    logic [WIDTH-1:0] wd3;

    writeback_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_pend1(q_pend1), .q_pend2(q_pend2), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]       a;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t             qa[$], qm[$];
    bit               last_mem = 1'b1;
    logic             e_we = 1'b0;
    logic [4:0]       e_wa = '0;
    logic [WIDTH-1:0] e_wd = '0;
    bit               acc_a, acc_m;
    int               n_cmp = 0, n_bad = 0;

    function automatic bit pend(input logic [4:0] x);
        if (x == 5'd31) return 1'b0;
        if (e_we && e_wa == x) return 1'b1;
        foreach (qa[i]) if (qa[i].a == x) return 1'b1;
        foreach (qm[i]) if (qm[i].a == x) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [74:0] exp_vec();
        return {e_we, e_wa, e_wd, qa.size() < DEPTH, qm.size() < DEPTH,
                pend(q_addr1), pend(q_addr2), qa.size() == 0 && qm.size() == 0 && !e_we};
    endfunction

    // Advance the model by one edge from the inputs as presented, then step past the edge.
    task automatic tick();
        ent_t e;
        bit ga, gm;
        if (rst) begin
            qa.delete(); qm.delete();
            e_we = 1'b0; e_wa = '0; e_wd = '0; last_mem = 1'b1; acc_a = 1'b0; acc_m = 1'b0;
        end else begin
            acc_a = alu_valid && qa.size() < DEPTH;
            acc_m = mem_valid && qm.size() < DEPTH;
            ga = qa.size() != 0 && (qm.size() == 0 || last_mem);
            gm = qm.size() != 0 && !ga;
            if (qa.size() != 0 && qm.size() != 0) last_mem = gm;
            e_we = 1'b0;
            if (ga || gm) begin
                if (ga) e = qa.pop_front();
                else e = qm.pop_front();
                e_we = e.a != 5'd31; e_wa = e.a; e_wd = e.d;
            end
            if (acc_a) begin e.a = alu_addr; e.d = alu_data; qa.push_back(e); end
            if (acc_m) begin e.a = mem_addr; e.d = mem_data; qm.push_back(e); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [55:0] n = '0;
        bit built = 1'b0;
        tick();
        n_cmp++; if ({we3, wa3, wd3} !== '0) begin n_bad++; $display("FAIL reset_wport: got %h expected 0", {we3, wa3, wd3}); end
        n_cmp++; if ({alu_ready, mem_ready, q_pend1, q_pend2, idle} !== 5'b00001) begin n_bad++; $display("FAIL reset_flags: got %b expected 00001", {alu_ready, mem_ready, q_pend1, q_pend2, idle}); end
        rst = 1'b0;
        alu_valid = 1'b1; mem_valid = 1'b1;
        alu_addr = 5'd1; mem_addr = 5'd2; alu_data = {8'hA0, n}; mem_data = {8'hB0, n};
        for (int c = 0; c < 20 && !built; c++) begin
            tick();
            if (acc_a) begin n++; alu_data = {8'hA0, n}; end
            if (acc_m) mem_data = {8'hB0, n};
            built = qa.size() >= 3;
        end
        n_cmp++; if (!built) begin n_bad++; $display("FAIL reset_buildup: got %0d entries expected 3", qa.size()); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({we3, wa3, wd3, alu_ready, mem_ready, idle} !== 73'b1) begin n_bad++; $display("FAIL reset_async: got %h expected 1", {we3, wa3, wd3, alu_ready, mem_ready, idle}); end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if ({we3, idle, alu_ready} !== 3'b011) begin n_bad++; $display("FAIL reset_after: got %b expected 011", {we3, idle, alu_ready}); end
        end
    endtask

    task automatic test_single();
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 64'hDEAD; q_addr1 = 5'd5; q_addr2 = 5'd6;
        tick();
        alu_valid = 1'b0;
        n_cmp++; if ({we3, q_pend1, q_pend2} !== 3'b010) begin n_bad++; $display("FAIL single_e: got %b expected 010", {we3, q_pend1, q_pend2}); end
        tick();
        n_cmp++; if ({we3, wa3, wd3, q_pend1} !== {1'b1, 5'd5, 64'hDEAD, 1'b1}) begin n_bad++; $display("FAIL single_write: got %h expected %h", {we3, wa3, wd3, q_pend1}, {1'b1, 5'd5, 64'hDEAD, 1'b1}); end
        tick();
        n_cmp++; if ({we3, q_pend1, idle} !== 3'b001) begin n_bad++; $display("FAIL single_done: got %b expected 001", {we3, q_pend1, idle}); end
    endtask

    task automatic test_contention();
        logic [4:0]       ord [4] = '{5'd1, 5'd3, 5'd2, 5'd4};
        logic [WIDTH-1:0] dat [4] = '{64'hA1, 64'hB3, 64'hA2, 64'hB4};
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 64'hA1;
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 64'hB3;
        tick();
        alu_addr = 5'd2; alu_data = 64'hA2; mem_addr = 5'd4; mem_data = 64'hB4;
        for (int k = 0; k < 4; k++) begin
            tick();
            alu_valid = 1'b0; mem_valid = 1'b0;
            n_cmp++; if ({we3, wa3, wd3} !== {1'b1, ord[k], dat[k]}) begin n_bad++; $display("FAIL contention_%0d: got %h expected %h", k, {we3, wa3, wd3}, {1'b1, ord[k], dat[k]}); end
        end
    endtask

    task automatic test_full();
        logic [55:0] na = '0, nm = '0;
        int pushes = 0, writes = 0;
        bit full_seen = 1'b0, held = 1'b0;
        do_reset();
        alu_valid = 1'b1; mem_valid = 1'b1;
        alu_addr = 5'd0; alu_data = {8'hA0, na}; mem_addr = 5'd8; mem_data = {8'hB0, nm};
        for (int c = 0; c < 30 && !full_seen; c++) begin
            tick();
            if (acc_a) begin pushes++; na++; alu_data = {8'hA0, na}; alu_addr = 5'(na % 8); end
            if (acc_m) begin nm++; mem_data = {8'hB0, nm}; end
            if (we3 && wd3[63:56] == 8'hA0) writes++;
            n_cmp++; if ({we3, wa3, wd3, alu_ready, mem_ready, q_pend1, q_pend2, idle} !== exp_vec()) begin n_bad++; $display("FAIL full_fill: got %h expected %h", {we3, wa3, wd3, alu_ready, mem_ready, q_pend1, q_pend2, idle}, exp_vec()); end
            full_seen = qa.size() == DEPTH;
        end
        n_cmp++; if (!full_seen || alu_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got ready=%b size=%0d expected ready=0 size=%0d", alu_ready, qa.size(), DEPTH); end
        mem_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (acc_a) begin pushes++; held = 1'b1; alu_valid = 1'b0; end
            if (we3 && wd3[63:56] == 8'hA0) writes++;
            n_cmp++; if ({we3, wa3, wd3, alu_ready, mem_ready, q_pend1, q_pend2, idle} !== exp_vec()) begin n_bad++; $display("FAIL full_drain: got %h expected %h", {we3, wa3, wd3, alu_ready, mem_ready, q_pend1, q_pend2, idle}, exp_vec()); end
        end
        n_cmp++; if (!held || writes != pushes || idle !== 1'b1) begin n_bad++; $display("FAIL full_count: got writes=%0d idle=%b held=%0d expected writes=%0d idle=1 held=1", writes, idle, held, pushes); end
    endtask

    task automatic test_r31();
        do_reset();
        mem_valid = 1'b1; mem_addr = 5'd31; mem_data = 64'h3131; q_addr1 = 5'd31; q_addr2 = 5'd31;
        tick();
        mem_valid = 1'b0;
        n_cmp++; if ({q_pend1, idle} !== 2'b00) begin n_bad++; $display("FAIL r31_buffered: got %b expected 00", {q_pend1, idle}); end
        tick();
        n_cmp++; if ({we3, wa3, wd3, q_pend1, idle} !== {1'b0, 5'd31, 64'h3131, 2'b01}) begin n_bad++; $display("FAIL r31_drain: got %h expected %h", {we3, wa3, wd3, q_pend1, idle}, {1'b0, 5'd31, 64'h3131, 2'b01}); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            alu_valid = i < 10; alu_addr = 5'(i + 1); alu_data = 64'hC0 + 64'(i);
            tick();
            n_cmp++; if (we3 !== (i >= 1 && i <= 10)) begin n_bad++; $display("FAIL wrap_we_%0d: got %b expected %b", i, we3, i >= 1 && i <= 10); end
            if (i >= 1 && i <= 10) begin
                n_cmp++; if ({wa3, wd3} !== {5'(i), 64'hC0 + 64'(i - 1)}) begin n_bad++; $display("FAIL wrap_data_%0d: got %h expected %h", i, {wa3, wd3}, {5'(i), 64'hC0 + 64'(i - 1)}); end
            end
        end
        alu_valid = 1'b0;
    endtask

    function automatic logic [4:0] rnd_addr();
        logic [2:0] r = 3'($urandom);
        return r == 3'd7 ? 5'd31 : {2'b00, r};
    endfunction

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (!alu_valid || acc_a) begin
                alu_valid = $urandom_range(0, 3) != 0; alu_addr = rnd_addr(); alu_data = {$urandom, $urandom};
            end
            if (!mem_valid || acc_m) begin
                mem_valid = $urandom_range(0, 2) != 0; mem_addr = rnd_addr(); mem_data = {$urandom, $urandom};
            end
            q_addr1 = rnd_addr(); q_addr2 = rnd_addr();
            tick();
            n_cmp++; if ({we3, wa3, wd3, alu_ready, mem_ready, q_pend1, q_pend2, idle} !== exp_vec()) begin n_bad++; $display("FAIL random_%0d: got %h expected %h", c, {we3, wa3, wd3, alu_ready, mem_ready, q_pend1, q_pend2, idle}, exp_vec()); end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_r31();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
